// File: rtl/uart_byte_tx.sv
// 8N1 UART byte transmitter with trigger/enable/status/finish handshake.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 10416,
    parameter int CNT_W        = 14
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       trigger,
    input  logic       enable,
    output logic       tx,
    output logic       status,
    output logic       finish
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             status_q, status_d;
    logic             finish_q, finish_d;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    assign bit_end = (cnt_q == LAST_CNT);

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            status_q <= 1'b0;
            finish_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            status_q <= status_d;
            finish_q <= finish_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    // Outputs are computed one cycle ahead so tx/status/finish come straight from flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        status_d = status_q;
        finish_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                tx_d     = 1'b1;
                status_d = 1'b0;
                if (trigger && enable) begin
                    shift_d  = tx_data;
                    cnt_d    = '0;
                    state_d  = START;
                    tx_d     = 1'b0;
                    status_d = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_d    = ^tx_data;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = par_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    state_d = STOP;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    state_d  = IDLE;
                    tx_d     = 1'b1;
                    status_d = 1'b0;
                    finish_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                tx_d     = 1'b1;
                status_d = 1'b0;
            end
        endcase
    end

    assign tx     = tx_q;
    assign status = status_q;
    assign finish = finish_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed scoreboard bench for uart_byte_tx with CLKS_PER_BIT=4.
// Covers the parity variant as well when UART_TX_PARITY_EN is defined.
module tb_uart_byte_tx;
    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       sysclk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       trigger;
    logic       enable;
    logic       tx;
    logic       status;
    logic       finish;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];

    always #5 sysclk = ~sysclk;

    uart_byte_tx #(.CLKS_PER_BIT(C), .CNT_W(4)) dut (
        .sysclk (sysclk),
        .reset  (reset),
        .tx_data(tx_data),
        .trigger(trigger),
        .enable (enable),
        .tx     (tx),
        .status (status),
        .finish (finish)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endtask

    task automatic request(input logic [7:0] d);
        @(negedge sysclk);
        tx_data = d;
        trigger = 1'b1;
        enable  = 1'b1;
        @(posedge sysclk);
        #1 trigger = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int n);
        repeat (n) begin
            @(negedge sysclk);
            chk({tag, " tx"}, tx, 1);
            chk({tag, " status"}, status, 0);
            chk({tag, " finish"}, finish, 0);
        end
    endtask

    // Call right after the accepting edge; samples every cycle of the frame, then the finish cycle.
    task automatic check_frame(input string tag, input int hook_at, input logic hook_trig,
                               input logic [7:0] hook_data, input bit hook_pulse);
        int   s = 0;
        logic b;
        for (int p = 0; p < NBITS; p++) begin
            chk({tag, " scoreboard"}, (exp_q.size() > 0), 1);
            b = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            for (int k = 0; k < C; k++) begin
                @(negedge sysclk);
                chk({tag, " tx"}, tx, b);
                chk({tag, " status"}, status, 1);
                chk({tag, " finish"}, finish, 0);
                if (hook_pulse && s == hook_at + 1) trigger = 1'b0;
                if (s == hook_at) begin
                    trigger = hook_trig;
                    enable  = 1'b1;
                    tx_data = hook_data;
                end
                s++;
            end
        end
        @(negedge sysclk);
        chk({tag, " end tx"}, tx, 1);
        chk({tag, " end status"}, status, 0);
        chk({tag, " end finish"}, finish, 1);
    endtask

    initial begin
        reset   = 1'b1;
        trigger = 1'b0;
        enable  = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("reset tx", tx, 1);
        chk("reset status", status, 0);
        chk("reset finish", finish, 0);
        reset = 1'b0;
        idle_check("idle", 20);

        push_frame(8'h55);
        request(8'h55);
        check_frame("f55", -1, 1'b0, 8'h00, 1'b0);
        idle_check("post55", 3);

        @(negedge sysclk);
        tx_data = 8'hA3;
        trigger = 1'b1;
        enable  = 1'b0;
        @(negedge sysclk);
        trigger = 1'b0;
        idle_check("en0", 10);
        push_frame(8'hA3);
        request(8'hA3);
        check_frame("fA3", -1, 1'b0, 8'h00, 1'b0);
        idle_check("postA3", 3);

        push_frame(8'h0F);
        request(8'h0F);
        check_frame("f0F busy", 10, 1'b1, 8'hFF, 1'b1);
        idle_check("no queue", 12);

        @(negedge sysclk);
        tx_data = 8'h81;
        trigger = 1'b1;
        enable  = 1'b1;
        @(posedge sysclk);
        #1;
        push_frame(8'h81);
        check_frame("held1", 5, 1'b1, 8'h3C, 1'b0);
        push_frame(8'h3C);
        check_frame("held2", 5, 1'b0, 8'h00, 1'b0);
        idle_check("post held", 12);

        request(8'h5A);
        repeat (14) @(negedge sysclk);
        reset = 1'b1;
        @(negedge sysclk);
        chk("midrst tx", tx, 1);
        chk("midrst status", status, 0);
        chk("midrst finish", finish, 0);
        reset = 1'b0;
        idle_check("after rst", 4 * NBITS + 5);
        push_frame(8'hC6);
        request(8'hC6);
        check_frame("fC6", -1, 1'b0, 8'h00, 1'b0);
        idle_check("postC6", 3);

`ifdef UART_TX_PARITY_EN
        push_frame(8'h07);
        request(8'h07);
        check_frame("par07", -1, 1'b0, 8'h00, 1'b0);
        idle_check("post07", 3);
        push_frame(8'h03);
        request(8'h03);
        check_frame("par03", -1, 1'b0, 8'h00, 1'b0);
        idle_check("post03", 3);
`endif

        chk("scoreboard drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
